// File: rtl/or_gate_mon_pkg.sv
// Shared types and helpers for the orGate sampling monitor.
// Imported by the monitor top and its delay pipeline.
package or_gate_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mon_state_e;

   localparam logic [1:0] BIN_00 = 2'd0;
   localparam logic [1:0] BIN_01 = 2'd1;
   localparam logic [1:0] BIN_10 = 2'd2;
   localparam logic [1:0] BIN_11 = 2'd3;

   // Counter widths up to 32 bits; holds at 2^w-1.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input int unsigned w
   );
      logic [31:0] lim;
      lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= lim) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/or_mon_delay.sv
// Valid/data shift register aligning expected values with the observed Y.
// LATENCY=0 is a wire; flush empties every stage.
module or_mon_delay
   import or_gate_mon_pkg::*;
#(
   parameter int LATENCY = 0,
   parameter int DW      = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   if (LATENCY == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, rst_n, flush};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
   end else begin : g_pipe
      logic [LATENCY-1:0]         vld_q, vld_d;
      logic [LATENCY-1:0][DW-1:0] dat_q, dat_d;

      always_comb begin
         vld_d = vld_q;
         dat_d = dat_q;
         if (flush) begin
            vld_d = '0;
            dat_d = '0;
         end else begin
            vld_d[0] = in_valid;
            dat_d[0] = in_data;
            for (int i = 1; i < LATENCY; i++) begin
               vld_d[i] = vld_q[i-1];
               dat_d[i] = dat_q[i-1];
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
         end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
         end
      end

      assign out_valid = vld_q[LATENCY-1];
      assign out_data  = dat_q[LATENCY-1];
   end

endmodule

// File: rtl/or_gate_monitor.sv
// Passive orGate checker: compares Y with a delayed A|B and keeps
// transaction, error and coverage counts over a start/stop window.
module or_gate_monitor
   import or_gate_mon_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 0,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               sample_valid,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic               mismatch,
   output logic [CNT_W-1:0]   txn_count,
   output logic [CNT_W-1:0]   err_count,
   output logic [4*CNT_W-1:0] cov_bins,
   output logic [CNT_W-1:0]   first_err_idx,
   output logic [WIDTH-1:0]   first_err_exp,
   output logic [WIDTH-1:0]   first_err_got
);

   localparam int DW = WIDTH + 2;

   mon_state_e state_q, state_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic mm_q, mm_d;
   logic [CNT_W-1:0] txn_q, txn_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [3:0][CNT_W-1:0] bins_q, bins_d;
   logic [CNT_W-1:0] fidx_q, fidx_d;
   logic [WIDTH-1:0] fexp_q, fexp_d;
   logic [WIDTH-1:0] fgot_q, fgot_d;

   logic          p_vld;
   logic [DW-1:0] p_dat;
   logic [1:0]    p_bin;
   logic [WIDTH-1:0] p_exp;
   logic cnt_en;
   logic miss;

   // Bin index is captured with the sample so it travels with its expected Y.
   or_mon_delay #(
      .LATENCY (LATENCY),
      .DW      (DW)
   ) u_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (start),
      .in_valid  (sample_valid),
      .in_data   ({a[0], b[0], a | b}),
      .out_valid (p_vld),
      .out_data  (p_dat)
   );

   assign p_bin  = p_dat[DW-1 -: 2];
   assign p_exp  = p_dat[WIDTH-1:0];
   assign cnt_en = (state_q == RUN) && p_vld && !start;
   assign miss   = (y !== p_exp);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (start) state_d = RUN;
                  else if (stop) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
      mm_d   = cnt_en && miss;
      txn_d  = txn_q;
      err_d  = err_q;
      bins_d = bins_q;
      fidx_d = fidx_q;
      fexp_d = fexp_q;
      fgot_d = fgot_q;
      if (start) begin
         txn_d  = '0;
         err_d  = '0;
         bins_d = '0;
         fidx_d = '0;
         fexp_d = '0;
         fgot_d = '0;
      end else if (cnt_en) begin
         txn_d = CNT_W'(sat_inc(32'(txn_q), CNT_W));
         bins_d[p_bin] = CNT_W'(sat_inc(32'(bins_q[p_bin]), CNT_W));
         if (miss) begin
            err_d = CNT_W'(sat_inc(32'(err_q), CNT_W));
            if (err_q == '0) begin
               fidx_d = txn_q;
               fexp_d = p_exp;
               fgot_d = y;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mm_q    <= 1'b0;
         txn_q   <= '0;
         err_q   <= '0;
         bins_q  <= '0;
         fidx_q  <= '0;
         fexp_q  <= '0;
         fgot_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mm_q    <= mm_d;
         txn_q   <= txn_d;
         err_q   <= err_d;
         bins_q  <= bins_d;
         fidx_q  <= fidx_d;
         fexp_q  <= fexp_d;
         fgot_q  <= fgot_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign mismatch      = mm_q;
   assign txn_count     = txn_q;
   assign err_count     = err_q;
   assign cov_bins      = bins_q;
   assign first_err_idx = fidx_q;
   assign first_err_exp = fexp_q;
   assign first_err_got = fgot_q;

endmodule

// File: tb/tb_or_gate_monitor.sv
// Directed bench for or_gate_monitor: three instances (latency 0,
// latency 2, 3-bit counters) share stimulus; expectations go through a queue.
module tb_or_gate_monitor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic sample_valid = 1'b0;
   logic a = 1'b0;
   logic b = 1'b0;
   logic fault = 1'b0;
   logic y0, y2, y3;
   logic p1 = 1'b0;
   logic p2 = 1'b0;

   always #5 clk = ~clk;

   assign y0 = (a | b) & ~fault;
   assign y3 = a | b;
   always @(posedge clk) begin
      p1 <= a | b;
      p2 <= p1;
   end
   assign y2 = p2;

   logic busy0, done0, mm0;
   logic [15:0] txn0, err0, fidx0;
   logic [63:0] cov0;
   logic fexp0, fgot0;

   logic busy2, done2, mm2;
   logic [15:0] txn2, err2, fidx2;
   logic [63:0] cov2;
   logic fexp2, fgot2;

   logic busy3, done3, mm3;
   logic [2:0] txn3, err3, fidx3;
   logic [11:0] cov3;
   logic fexp3, fgot3;

   or_gate_monitor #(.WIDTH(1), .LATENCY(0), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .sample_valid(sample_valid), .a(a), .b(b), .y(y0),
      .busy(busy0), .done(done0), .mismatch(mm0),
      .txn_count(txn0), .err_count(err0), .cov_bins(cov0),
      .first_err_idx(fidx0), .first_err_exp(fexp0),
      .first_err_got(fgot0)
   );

   or_gate_monitor #(.WIDTH(1), .LATENCY(2), .CNT_W(16)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .sample_valid(sample_valid), .a(a), .b(b), .y(y2),
      .busy(busy2), .done(done2), .mismatch(mm2),
      .txn_count(txn2), .err_count(err2), .cov_bins(cov2),
      .first_err_idx(fidx2), .first_err_exp(fexp2),
      .first_err_got(fgot2)
   );

   or_gate_monitor #(.WIDTH(1), .LATENCY(0), .CNT_W(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .sample_valid(sample_valid), .a(a), .b(b), .y(y3),
      .busy(busy3), .done(done3), .mismatch(mm3),
      .txn_count(txn3), .err_count(err3), .cov_bins(cov3),
      .first_err_idx(fidx3), .first_err_exp(fexp3),
      .first_err_got(fgot3)
   );

   int n_tests = 0;
   int n_fail = 0;
   int mm_cnt = 0;
   logic [63:0] exp_q[$];
   string tag_q[$];

   always @(negedge clk) if (mm0 === 1'b1) mm_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [63:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic chk(input logic [63:0] obs);
      logic [63:0] e;
      string t;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty got %0h", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", t, obs, e);
         end
      end
   endtask

   task automatic smp(input logic [1:0] ab);
      a = ab[1];
      b = ab[0];
      sample_valid = 1'b1;
      tick();
   endtask

   task automatic idle();
      sample_valid = 1'b0;
      a = 1'b0;
      b = 1'b0;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      sample_valid = 1'b0;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      sample_valid = 1'b0;
      tick();
      stop = 1'b0;
   endtask

   logic [63:0] one4;

   initial begin
      one4 = {16'd1, 16'd1, 16'd1, 16'd1};

      // reset state
      push("rst_busy", 0);
      push("rst_done", 0);
      push("rst_txn", 0);
      push("rst_cov", 0);
      repeat (2) tick();
      chk(64'(busy0));
      chk(64'(done0));
      chk(64'(txn0));
      chk(cov0);
      rst_n = 1'b1;
      tick();

      // reset in the middle of a window
      push("mid_txn_before", 5);
      push("mid_busy", 0);
      push("mid_done", 0);
      push("mid_txn", 0);
      push("mid_err", 0);
      push("mid_cov", 0);
      push("mid_mm", 0);
      pulse_start();
      for (int i = 0; i < 5; i++) smp(2'(i));
      idle();
      chk(64'(txn0));
      rst_n = 1'b0;
      tick();
      chk(64'(busy0));
      chk(64'(done0));
      chk(64'(txn0));
      chk(64'(err0));
      chk(cov0);
      chk(64'(mm0));
      rst_n = 1'b1;
      tick();

      // correct DUT, all four combinations
      push("ok_txn", 4);
      push("ok_err", 0);
      push("ok_cov", one4);
      push("ok_done", 1);
      push("ok_busy", 0);
      push("ok_mm_cnt", 0);
      pulse_start();
      mm_cnt = 0;
      smp(2'b00);
      smp(2'b01);
      smp(2'b10);
      smp(2'b11);
      pulse_stop();
      tick();
      chk(64'(txn0));
      chk(64'(err0));
      chk(cov0);
      chk(64'(done0));
      chk(64'(busy0));
      chk(64'(mm_cnt));

      // injected faults on samples 3 and 4
      push("f1_err", 1);
      push("f1_mm", 1);
      push("f1_idx", 2);
      push("f1_exp", 1);
      push("f1_got", 0);
      push("f2_err", 2);
      push("f2_idx", 2);
      push("f2_exp", 1);
      push("f2_got", 0);
      push("f2_mm_after", 0);
      push("f2_mm_cnt", 2);
      pulse_start();
      mm_cnt = 0;
      smp(2'b00);
      smp(2'b01);
      fault = 1'b1;
      smp(2'b10);
      chk(64'(err0));
      chk(64'(mm0));
      chk(64'(fidx0));
      chk(64'(fexp0));
      chk(64'(fgot0));
      smp(2'b11);
      fault = 1'b0;
      chk(64'(err0));
      chk(64'(fidx0));
      chk(64'(fexp0));
      chk(64'(fgot0));
      idle();
      idle();
      chk(64'(mm0));
      chk(64'(mm_cnt));

      // latency 2, stop with the last sample: two samples in flight lost
      push("l2a_txn", 8);
      push("l2a_err", 0);
      push("l2a_done", 1);
      pulse_start();
      for (int i = 0; i < 9; i++) smp(2'(i));
      stop = 1'b1;
      smp(2'b01);
      stop = 1'b0;
      idle();
      idle();
      idle();
      chk(64'(txn2));
      chk(64'(err2));
      chk(64'(done2));

      // latency 2, stop two cycles after the last sample
      push("l2b_txn", 10);
      push("l2b_err", 0);
      pulse_start();
      for (int i = 0; i < 10; i++) smp(2'(i));
      idle();
      pulse_stop();
      idle();
      idle();
      chk(64'(txn2));
      chk(64'(err2));

      // 3-bit counters saturate
      push("sat_txn", 7);
      push("sat_cov", 64'h0E00);
      push("sat_err", 0);
      pulse_start();
      for (int i = 0; i < 9; i++) smp(2'b11);
      idle();
      chk(64'(txn3));
      chk(64'(cov3));
      chk(64'(err3));

      // start and stop together while running
      push("ss_txn", 0);
      push("ss_cov", 0);
      push("ss_busy", 1);
      push("ss_done", 0);
      start = 1'b1;
      stop = 1'b1;
      sample_valid = 1'b0;
      tick();
      start = 1'b0;
      stop = 1'b0;
      tick();
      chk(64'(txn3));
      chk(64'(cov3));
      chk(64'(busy3));
      chk(64'(done3));

      // stop while idle is ignored
      push("idle_stop_done", 0);
      push("idle_stop_busy", 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      pulse_stop();
      tick();
      chk(64'(done0));
      chk(64'(busy0));

      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/or_gate_monitor.md
Name: or_gate_monitor

Overview:
- Synthesizable, passive, sampling monitor: the receive-side counterpart of the stimulus driver on the orGate interface.
- Observes the A/B/Y nets of an orGate instance and checks each sampled Y against the expected A|B.
  - The expected value can be taken after a configurable pipeline delay.
- Counts transactions, mismatches and input-combination coverage over a start/stop measurement window.
- Sits beside the DUT in the bench or in an on-chip self-test harness and never drives DUT nets.

Parameters:
- WIDTH, 1, bit width of A, B and Y.
- LATENCY, 0, cycles between an A/B sample and its corresponding Y (legal 0..3).
- CNT_W, 16, width of all counters; counters saturate at all-ones.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: clear counters and open the window.
- stop  in  1  single-cycle pulse: close the window.
- sample_valid  in  1  A/B are a valid transaction this cycle.
- a  in  WIDTH  monitored DUT input A.
- b  in  WIDTH  monitored DUT input B.
- y  in  WIDTH  monitored DUT output Y.
- busy  out  1  window open (RUN state).
- done  out  1  window closed with results held (DONE state).
- mismatch  out  1  one-cycle pulse on each detected mismatch.
- txn_count  out  CNT_W  checked transactions.
- err_count  out  CNT_W  mismatching transactions.
- cov_bins  out  4*CNT_W  per-combination counts, bit-0 of {a,b}: bin index {a[0],b[0]}, bin 0 at LSBs.
- first_err_idx  out  CNT_W  txn_count value at the first mismatch.
- first_err_exp  out  WIDTH  expected Y at the first mismatch.
- first_err_got  out  WIDTH  observed Y at the first mismatch.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All counters, first_err_* fields, busy, done, mismatch and the delay pipeline clear to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --stop--> DONE.
  - DONE --start--> RUN.
  - In RUN, start restarts the window: counters clear and the FSM stays in RUN.
  - stop in IDLE or DONE is ignored.
  - start and stop in the same cycle: start wins.
- Entering RUN clears all counters, first_err_* fields and the pipeline, effective the cycle after start.
- busy=1 exactly in RUN; done=1 exactly in DONE. Both are registered.
- Expected value and delay pipeline:
  - Expected = a|b, bitwise.
  - LATENCY=0: compare against the same-cycle y.
  - LATENCY=N: {valid, expected} passes through an N-deep shift register and is compared with y when it emerges.
- Accounting: a sample counts only if its valid bit emerges from the pipeline while in RUN.
  - Samples in flight at stop are discarded.
  - Samples taken before start are discarded; the pipeline is flushed on start.
- Each counted sample:
  - txn_count += 1.
  - The cov_bins entry for {a[0],b[0]}, captured at sample time, += 1.
  - On mismatch: err_count += 1 and mismatch pulses high for one cycle, registered, one cycle after the compare.
- First-error capture:
  - Written only when err_count == 0 at the compare.
  - first_err_idx takes the pre-increment txn_count.
  - The fields then hold until the next start or reset.
- Saturation: every counter holds at 2^CNT_W-1. No wrap.
- Results are readable in RUN (live) and in DONE (frozen).
- X/Z on y at compare counts as a mismatch: compare with case inequality in simulation.

Decomposition:
- Package or_gate_mon_pkg:
  - State enum mon_state_e {IDLE, RUN, DONE}.
  - Bin index constants BIN_00..BIN_11.
  - A saturating-increment function.
- Sub-module or_mon_delay: parameterized LATENCY-deep valid/data pipeline with synchronous flush; pass-through when LATENCY=0.
- Counters and FSM stay in the top.

Test Plan:
- Reset mid-RUN: after 5 transactions, pulse rst_n low for 1 cycle → all outputs 0, FSM in IDLE, busy=0.
- LATENCY=0, WIDTH=1, correct DUT: start, apply 00,01,10,11 valid for 4 cycles, stop → txn_count=4, err_count=0, each cov bin=1, done=1, mismatch never high.
- Injected fault, force Y=0 on the third sample (a=1,b=0):
  - Result: err_count=1, mismatch high for one cycle, first_err_idx=2, first_err_exp=1, first_err_got=0.
  - A second fault on sample 4 → err_count=2, first_err_* unchanged.
- LATENCY=2 with Y delayed two cycles: 10 valid samples, then stop immediately after the last sample → txn_count=8, with the 2 in flight discarded.
- Same run with stop 2 cycles after the last sample → txn_count=10, err_count=0.
- CNT_W=3: 9 valid samples, all input combo 11 → txn_count=7, bin 3 = 7, saturated, no wrap.
- start and stop asserted together in RUN → counters clear and busy stays 1.
- stop in IDLE → done stays 0.
